// File: rtl/sfp_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sfp_link_monitor
// Description : Per-lane 10G link qualification (DOWN/SYNC/UP/FAULT) with
//               flap counters and selectable counter readout.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_link_monitor #(
    parameter int CHANNELS    = 4,
    parameter int LOCK_CYCLES = 156250,
    parameter int HOLD_CYCLES = 1024,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  block_lock,
    input  logic [CHANNELS-1:0]  hi_ber,
    input  logic [CHANNELS-1:0]  los,
    input  logic                 clear_counts,
    input  logic [3:0]           sel,
    output logic [CHANNELS-1:0]  link_up,
    output logic [CHANNELS-1:0]  link_fault,
    output logic [CHANNELS-1:0]  link_change,
    output logic                 any_link_up,
    output logic                 all_link_up,
    output logic [CNT_WIDTH-1:0] flap_count
);

    localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int TMR_WIDTH  = $clog2(MAX_CYCLES);

    localparam logic [TMR_WIDTH-1:0] LOCK_LAST = TMR_WIDTH'(LOCK_CYCLES - 1);
    localparam logic [TMR_WIDTH-1:0] HOLD_LAST = TMR_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [TMR_WIDTH-1:0] TMR_ONE   = TMR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    localparam logic [1:0] ST_DOWN  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_UP    = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [CHANNELS-1:0]  lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;
    logic [CHANNELS-1:0]  hi_ber_meta_q, hi_ber_meta_d, hi_ber_sync_q, hi_ber_sync_d;
    logic [CHANNELS-1:0]  los_meta_q, los_meta_d, los_sync_q, los_sync_d;
    logic [CHANNELS-1:0]  lane_ok;
    logic [CHANNELS-1:0]  lane_drop;

    logic [1:0]           state_q [CHANNELS];
    logic [1:0]           state_d [CHANNELS];
    logic [TMR_WIDTH-1:0] timer_q [CHANNELS];
    logic [TMR_WIDTH-1:0] timer_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_pad [16];

    logic [CHANNELS-1:0]  link_up_q, link_up_d;
    logic [CHANNELS-1:0]  link_fault_q, link_fault_d;
    logic [CHANNELS-1:0]  link_change_q, link_change_d;
    logic                 any_link_up_q, any_link_up_d;
    logic                 all_link_up_q, all_link_up_d;
    logic [CNT_WIDTH-1:0] flap_count_q, flap_count_d;

    // Readout table is always 16 deep so any sel value indexes safely.
    for (genvar k = 0; k < 16; k++) begin : g_pad
        if (k < CHANNELS) begin : g_live
            assign cnt_pad[k] = cnt_q[k];
        end else begin : g_zero
            assign cnt_pad[k] = '0;
        end
    end

    assign lane_ok = lock_sync_q & ~hi_ber_sync_q & ~los_sync_q;

    always_comb begin
        lock_meta_d   = block_lock;
        lock_sync_d   = lock_meta_q;
        hi_ber_meta_d = hi_ber;
        hi_ber_sync_d = hi_ber_meta_q;
        los_meta_d    = los;
        los_sync_d    = los_meta_q;
        lane_drop     = '0;
        link_up_d     = '0;
        link_fault_d  = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];

            case (state_q[i])
                ST_DOWN: begin
                    if (lane_ok[i]) begin
                        state_d[i] = ST_SYNC;
                        timer_d[i] = '0;
                    end
                end
                ST_SYNC: begin
                    if (!lane_ok[i]) begin
                        state_d[i] = ST_DOWN;
                    end else if (timer_q[i] == LOCK_LAST) begin
                        state_d[i] = ST_UP;
                    end else begin
                        timer_d[i] = timer_q[i] + TMR_ONE;
                    end
                end
                ST_UP: begin
                    if (los_sync_q[i] || !lock_sync_q[i]) begin
                        state_d[i]   = ST_DOWN;
                        lane_drop[i] = 1'b1;
                    end else if (hi_ber_sync_q[i]) begin
                        state_d[i] = ST_FAULT;
                        timer_d[i] = '0;
                    end
                end
                ST_FAULT: begin
                    if (los_sync_q[i] || !lock_sync_q[i]) begin
                        state_d[i]   = ST_DOWN;
                        lane_drop[i] = 1'b1;
                    end else if (!hi_ber_sync_q[i]) begin
                        state_d[i] = ST_UP;
                    end else if (timer_q[i] == HOLD_LAST) begin
                        state_d[i]   = ST_DOWN;
                        lane_drop[i] = 1'b1;
                    end else begin
                        timer_d[i] = timer_q[i] + TMR_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_DOWN;
                end
            endcase

            // A drop coinciding with a clear is still recorded.
            if (clear_counts) begin
                cnt_d[i] = lane_drop[i] ? CNT_ONE : '0;
            end else if (lane_drop[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            link_up_d[i]    = (state_d[i] == ST_UP) || (state_d[i] == ST_FAULT);
            link_fault_d[i] = (state_d[i] == ST_FAULT);
        end

        link_change_d = link_up_d ^ link_up_q;
        any_link_up_d = |link_up_q;
        all_link_up_d = &link_up_q;
        flap_count_d  = cnt_pad[sel];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta_q   <= '0;
            lock_sync_q   <= '0;
            hi_ber_meta_q <= '0;
            hi_ber_sync_q <= '0;
            los_meta_q    <= '0;
            los_sync_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_DOWN;
                timer_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            link_up_q     <= '0;
            link_fault_q  <= '0;
            link_change_q <= '0;
            any_link_up_q <= 1'b0;
            all_link_up_q <= 1'b0;
            flap_count_q  <= '0;
        end else begin
            lock_meta_q   <= lock_meta_d;
            lock_sync_q   <= lock_sync_d;
            hi_ber_meta_q <= hi_ber_meta_d;
            hi_ber_sync_q <= hi_ber_sync_d;
            los_meta_q    <= los_meta_d;
            los_sync_q    <= los_sync_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            link_up_q     <= link_up_d;
            link_fault_q  <= link_fault_d;
            link_change_q <= link_change_d;
            any_link_up_q <= any_link_up_d;
            all_link_up_q <= all_link_up_d;
            flap_count_q  <= flap_count_d;
        end
    end

    assign link_up     = link_up_q;
    assign link_fault  = link_fault_q;
    assign link_change = link_change_q;
    assign any_link_up = any_link_up_q;
    assign all_link_up = all_link_up_q;
    assign flap_count  = flap_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sfp_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfp_link_monitor
// Description : Directed plus randomized bench for sfp_link_monitor against a
//               run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfp_link_monitor;

    localparam int CH = 4;
    localparam int LC = 16;
    localparam int HC = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] block_lock = '0;
    logic [CH-1:0] hi_ber = '0;
    logic [CH-1:0] los = '0;
    logic          clear_counts = 1'b0;
    logic [3:0]    sel = '0;
    logic [CH-1:0] link_up, link_fault, link_change;
    logic          any_link_up, all_link_up;
    logic [CW-1:0] flap_count;

    sfp_link_monitor #(
        .CHANNELS   (CH),
        .LOCK_CYCLES(LC),
        .HOLD_CYCLES(HC),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .block_lock  (block_lock),
        .hi_ber      (hi_ber),
        .los         (los),
        .clear_counts(clear_counts),
        .sel         (sel),
        .link_up     (link_up),
        .link_fault  (link_fault),
        .link_change (link_change),
        .any_link_up (any_link_up),
        .all_link_up (all_link_up),
        .flap_count  (flap_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: link qualifies after LC+1 consecutive clean samples
    // seen past a two-stage delay; while up, HC+1 consecutive hi_ber samples
    // or any lock/los loss take it down.
    logic [CH-1:0] m_meta_lock = '0, m_meta_hib = '0, m_meta_los = '0;
    logic [CH-1:0] m_s_lock = '0, m_s_hib = '0, m_s_los = '0;
    int            m_run [CH];
    int            m_hic [CH];
    int            m_cnt [CH];
    logic [CH-1:0] exp_up = '0, exp_fault = '0, exp_change = '0;
    logic          exp_any = 1'b0, exp_all = 1'b0;
    logic [CW-1:0] exp_flap = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [CH-1:0] old_up;
        logic          ok;
        logic          drop;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 0;
                m_hic[i] = 0;
                m_cnt[i] = 0;
            end
            {m_meta_lock, m_meta_hib, m_meta_los} = '0;
            {m_s_lock, m_s_hib, m_s_los} = '0;
            exp_up = '0; exp_fault = '0; exp_change = '0;
            exp_any = 1'b0; exp_all = 1'b0; exp_flap = '0;
        end else begin
            old_up   = exp_up;
            exp_flap = (sel < 4'(CH)) ? CW'(m_cnt[sel[1:0]]) : '0;
            exp_any  = |old_up;
            exp_all  = &old_up;
            for (int i = 0; i < CH; i++) begin
                ok   = m_s_lock[i] & ~m_s_hib[i] & ~m_s_los[i];
                drop = 1'b0;
                if (!exp_up[i]) begin
                    m_run[i] = ok ? m_run[i] + 1 : 0;
                    if (m_run[i] == LC + 1) begin
                        exp_up[i] = 1'b1;
                        m_run[i]  = 0;
                        m_hic[i]  = 0;
                    end
                end else if (m_s_los[i] || !m_s_lock[i]) begin
                    exp_up[i] = 1'b0;
                    m_hic[i]  = 0;
                    drop      = 1'b1;
                end else if (m_s_hib[i]) begin
                    m_hic[i]++;
                    if (m_hic[i] == HC + 1) begin
                        exp_up[i] = 1'b0;
                        m_hic[i]  = 0;
                        drop      = 1'b1;
                    end
                end else begin
                    m_hic[i] = 0;
                end
                if (clear_counts)                  m_cnt[i] = drop ? 1 : 0;
                else if (drop && m_cnt[i] < 3)     m_cnt[i]++;
                exp_fault[i] = exp_up[i] && (m_hic[i] > 0);
            end
            exp_change = exp_up ^ old_up;
            m_s_lock = m_meta_lock; m_s_hib = m_meta_hib; m_s_los = m_meta_los;
            m_meta_lock = block_lock; m_meta_hib = hi_ber; m_meta_los = los;
        end
        @(posedge clk);
        #1;
        check("link_up",     32'(link_up),     32'(exp_up));
        check("link_fault",  32'(link_fault),  32'(exp_fault));
        check("link_change", 32'(link_change), 32'(exp_change));
        check("any_link_up", 32'(any_link_up), 32'(exp_any));
        check("all_link_up", 32'(all_link_up), 32'(exp_all));
        check("flap_count",  32'(flap_count),  32'(exp_flap));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_hic[i] = 0; m_cnt[i] = 0;
        end

        // Reset state
        rst_n = 1'b0;
        ticks(2);
        check("reset_link_up", 32'(link_up), 32'h0);
        check("reset_flap",    32'(flap_count), 32'h0);
        rst_n = 1'b1;

        // Lane 0 qualifies LC+2 edges after clean inputs appear
        block_lock = 4'b0001;
        ticks(18);
        check("lane0_not_yet_up", 32'(link_up), 32'h0);
        tick();
        check("lane0_up",     32'(link_up),     32'h1);
        check("lane0_change", 32'(link_change), 32'h1);
        check("lane0_all",    32'(all_link_up), 32'h0);
        tick();
        check("lane0_change_gone", 32'(link_change), 32'h0);

        // Lane 1 lock glitch restarts qualification
        block_lock[1] = 1'b1;
        ticks(10);
        block_lock[1] = 1'b0;
        tick();
        block_lock[1] = 1'b1;
        ticks(18);
        check("lane1_restart_not_up", 32'(link_up[1]), 32'h0);
        tick();
        check("lane1_restart_up", 32'(link_up[1]), 32'h1);

        // Lane 2 short hi_ber burst tolerated, long burst times out
        block_lock[2] = 1'b1;
        sel = 4'd2;
        ticks(20);
        hi_ber[2] = 1'b1;
        ticks(5);
        hi_ber[2] = 1'b0;
        ticks(8);
        check("lane2_short_ber_up",  32'(link_up[2]), 32'h1);
        check("lane2_short_ber_cnt", 32'(flap_count), 32'h0);
        hi_ber[2] = 1'b1;
        ticks(20);
        hi_ber[2] = 1'b0;
        ticks(2);
        check("lane2_long_ber_down", 32'(link_up[2]), 32'h0);
        check("lane2_long_ber_cnt",  32'(flap_count), 32'h1);

        // Lane 3 flaps five times, counter saturates; clear races a drop
        sel = 4'd3;
        block_lock[3] = 1'b1;
        for (int d = 0; d < 5; d++) begin
            los[3] = 1'b0;
            ticks(22);
            los[3] = 1'b1;
            ticks(3);
        end
        los[3] = 1'b0;
        tick();
        check("lane3_saturated", 32'(flap_count), 32'h3);
        ticks(22);
        los[3] = 1'b1;
        ticks(2);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        los[3] = 1'b0;
        tick();
        check("lane3_clear_with_drop", 32'(flap_count), 32'h1);

        // All lanes up, then a one-cycle reset
        block_lock = 4'hf; hi_ber = '0; los = '0;
        ticks(24);
        check("all_up",      32'(link_up),     32'hf);
        check("all_up_flag", 32'(all_link_up), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_link_up", 32'(link_up),     32'h0);
        check("rst_change",  32'(link_change), 32'h0);
        ticks(18);
        check("rst_no_early_up", 32'(link_up), 32'h0);
        tick();
        check("rst_requalified", 32'(link_up), 32'hf);

        // Out-of-range select reads zero
        sel = 4'd7;
        tick();
        check("sel_out_of_range", 32'(flap_count), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 63) == 0) block_lock[i] = ~block_lock[i];
                if (hi_ber[i]) begin
                    if ($urandom_range(0, 7) == 0) hi_ber[i] = 1'b0;
                end else if ($urandom_range(0, 47) == 0) hi_ber[i] = 1'b1;
                if (los[i]) begin
                    if ($urandom_range(0, 5) == 0) los[i] = 1'b0;
                end else if ($urandom_range(0, 99) == 0) los[i] = 1'b1;
            end
            clear_counts = ($urandom_range(0, 63) == 0);
            sel          = 4'($urandom_range(0, 15));
            rst_n        = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfp_link_monitor.md
SFP_LINK_MONITOR -- requirements
Module: sfp_link_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of 10G PHY lanes monitored (1..16).
REQ-002 SHALL have parameter LOCK_CYCLES, default 156250: clean-lock qualification time in clk cycles (>=2).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1024: max hi_ber tolerance while up, in clk cycles (>=2).
REQ-004 SHALL have parameter CNT_WIDTH, default 8: per-channel flap counter width.
REQ-005 SHALL have one clock; reset is synchronous and active-low: port clk, input, 1, sole clock.
REQ-006 SHALL have rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have block_lock, input, CHANNELS, PHY rx_block_lock per lane, asynchronous.
REQ-008 SHALL have hi_ber, input, CHANNELS, PHY rx_hi_ber per lane, asynchronous.
REQ-009 SHALL have los, input, CHANNELS, SFP loss-of-signal per lane, asynchronous.
REQ-010 SHALL have clear_counts, input, 1, synchronous pulse zeroing all flap counters.
REQ-011 SHALL have sel, input, 4, channel index for counter readout.
REQ-012 SHALL have link_up, output, CHANNELS, qualified link state per lane.
REQ-013 SHALL have link_fault, output, CHANNELS, high while lane is in FAULT.
REQ-014 SHALL have link_change, output, CHANNELS, one-cycle pulse on every link_up edge.
REQ-015 SHALL have any_link_up / all_link_up, output, 1 each, OR / AND reduction of link_up.
REQ-016 SHALL have flap_count, output, CNT_WIDTH, registered counter of channel sel.

Function
REQ-017 SHALL pass block_lock, hi_ber, los through a 2-flop synchronizer per bit; "ok" = lock_s & ~hi_ber_s & ~los_s.
REQ-018 SHALL run one independent FSM per lane, states DOWN, SYNC, UP, FAULT, plus a per-lane timer of ceil(log2(max(LOCK_CYCLES,HOLD_CYCLES))) bits.
REQ-019 DOWN: link_up=0, link_fault=0; ok -> SYNC with timer=0; else stay.
REQ-020 SYNC: link_up=0; ~ok -> DOWN; else timer+1; when timer==LOCK_CYCLES-1 -> UP.
REQ-021 UP: link_up=1; los_s or ~lock_s -> DOWN; else hi_ber_s -> FAULT with timer=0; else stay.
REQ-022 FAULT: link_up=1, link_fault=1; los_s or ~lock_s -> DOWN; ~hi_ber_s -> UP; timer==HOLD_CYCLES-1 -> DOWN; else timer+1.
REQ-023 link_up SHALL be a registered state decode; link_change[i] SHALL be high for exactly the cycle after link_up[i] toggles.
REQ-024 Latency: inputs stable ok from edge 0 -> link_up high after edge LOCK_CYCLES+2; lock loss at edge 0 -> link_up low after edge 2.
REQ-025 Flap counter SHALL increment on every UP->DOWN or FAULT->DOWN transition, saturating at 2^CNT_WIDTH-1.
REQ-026 clear_counts SHALL zero all counters next edge; if a drop occurs the same cycle, that counter becomes 1.
REQ-027 flap_count SHALL equal counter[sel] registered one cycle; sel>=CHANNELS yields 0.
REQ-028 any_link_up/all_link_up SHALL be registered from link_up (one cycle later than link_up).

Reset
REQ-029 rst_n low at a clk edge SHALL force all FSMs to DOWN, timers, counters, synchronizers to 0, and all outputs to 0 on that edge.
REQ-030 Reset mid-SYNC or mid-FAULT SHALL abandon qualification; no link_change pulse and no counter increment result from the reset.
REQ-031 After rst_n rises, lanes with ok held SHALL re-qualify per REQ-024.

Verification (bench parameters CHANNELS=4, LOCK_CYCLES=16, HOLD_CYCLES=8, CNT_WIDTH=2)
REQ-032 Lane 0 lock=1, hi_ber=0, los=0 from edge 0 -> link_up=4'b0001 after edge 18, link_change[0] pulse one cycle, all_link_up=0.
REQ-033 Lane 1 ok for 10 cycles then lock glitch low 1 cycle -> no link_up; qualification restarts, link_up[1] after 16 clean cycles plus sync.
REQ-034 Lane 2 up, hi_ber=1 for 5 cycles -> link_fault[2] high 5 cycles, link_up stays 1, counter[2]=0; hi_ber=1 for 20 cycles -> DOWN 8 cycles after FAULT entry, counter[2]=1.
REQ-035 Lane 3 dropped 5 times by los -> sel=3 gives flap_count=3 (saturated); clear_counts pulsed with drop same cycle -> flap_count=1.
REQ-036 All 4 lanes up, rst_n low 1 cycle -> all outputs 0 next edge, no link_change pulse, counters 0; lanes re-up after edge 18 post-reset.
REQ-037 sel=7 -> flap_count=0 one cycle later.
